// File: rtl/image_frame_writer_pkg.sv
// Shared types and constants for the 1-bit framebuffer writer.
// The display reader also uses the default geometry and ADDR_W derivation.
package image_frame_writer_pkg;

  localparam int DEF_IMAGE_WIDTH  = 640;
  localparam int DEF_IMAGE_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wr_state_e;

  // Smallest address width that holds every pixel index of a w x h frame.
  function automatic int addr_width(input int w, input int h);
    return (w * h <= 1) ? 1 : $clog2(w * h);
  endfunction

endpackage

// File: rtl/image_frame_writer_raster_counter.sv
// raster_counter: row/column tracker for a raster stream.
// Ports: clk, reset, adv_i (step one pixel), restart_i (step from (0,0)),
// row_o/col_o (next expected pixel), last_o (stepped pixel ends the frame).
module raster_counter #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_i,
  input  logic        restart_i,
  output logic [15:0] row_o,
  output logic [15:0] col_o,
  output logic        last_o
);

  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [15:0] base_row, base_col;

  // A restart makes the current beat pixel (0,0), then steps normally.
  assign base_row = restart_i ? 16'd0 : row_q;
  assign base_col = restart_i ? 16'd0 : col_q;
  assign last_o   = (base_row == LAST_ROW) && (base_col == LAST_COL);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (adv_i) begin
      if (base_col == LAST_COL) begin
        col_d = 16'd0;
        row_d = last_o ? 16'd0 : base_row + 16'd1;
      end else begin
        col_d = base_col + 16'd1;
        row_d = base_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= 16'd0;
      col_q <= 16'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/image_frame_writer.sv
// Writer side of the 1-bit framebuffer: pixel stream -> registered writes.
// Ports: clk, reset, in_valid/in_ready/in_pixel/in_sof/in_eol (stream),
// wr_en/wr_addr/wr_data (framebuffer), row/column, busy, frame_done, error.
// Optional IMAGE_FRAME_WRITER_STATS_EN adds on_count (lit pixels per frame).
module image_frame_writer
  import image_frame_writer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int ADDR_W       = addr_width(IMAGE_WIDTH, IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_pixel,
  input  logic              in_sof,
  input  logic              in_eol,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [15:0]       row,
  output logic [15:0]       column,
  output logic              busy,
  output logic              frame_done,
`ifdef IMAGE_FRAME_WRITER_STATS_EN
  output logic [ADDR_W:0]   on_count,
`endif
  output logic              error
);

  localparam logic [15:0]       LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(IMAGE_WIDTH);

  wr_state_e         state_q;
  logic              in_ready_q, busy_q, frame_done_q, error_q;
  logic              wr_en_q, wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, cur_addr;
  logic              accept, wr_fire, eol_bad, last;

  assign accept  = in_valid & in_ready_q;
  // Non-sof beats in IDLE are consumed but never written.
  assign wr_fire = accept & ((state_q == ST_ACTIVE) | in_sof);

  assign cur_addr  = ADDR_W'(row) * WIDTH_A + ADDR_W'(column);
  assign wr_addr_d = in_sof ? '0 : cur_addr;
  assign eol_bad   = in_eol != (column == LAST_COL);

  raster_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .adv_i     (wr_fire),
    .restart_i (wr_fire & in_sof),
    .row_o     (row),
    .col_o     (column),
    .last_o    (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
    end else begin
      wr_en_q      <= wr_fire;
      frame_done_q <= 1'b0;
      if (wr_fire) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= in_pixel;
      end
      unique case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          if (wr_fire) begin
            // sof restarts the line count, so eol is not judged.
            if (state_q == ST_IDLE)
              error_q <= 1'b0;
            else if (in_sof || eol_bad)
              error_q <= 1'b1;
            if (last) begin
              state_q      <= ST_DONE;
              in_ready_q   <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= ST_ACTIVE;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMAGE_FRAME_WRITER_STATS_EN
  logic [ADDR_W:0] ones_q, on_count_q;

  // on_count takes the tally as DONE ends, after the last pixel is counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q     <= '0;
      on_count_q <= '0;
    end else begin
      if (wr_fire && in_sof)
        ones_q <= {{ADDR_W{1'b0}}, in_pixel};
      else if (wr_fire && in_pixel)
        ones_q <= ones_q + 1'b1;
      if (state_q == ST_DONE)
        on_count_q <= ones_q;
    end
  end

  assign on_count = on_count_q;
`endif

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_image_frame_writer.sv
// Directed/randomized bench for image_frame_writer on a 4x3 frame.
// Expected values come from a flat pixel-index model of the stream rules.
module tb_image_frame_writer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;

  logic          clk = 0;
  logic          reset = 0;
  logic          in_valid = 0, in_pixel = 0, in_sof = 0, in_eol = 0;
  logic          in_ready, wr_en, wr_data, busy, frame_done, error;
  logic [AW-1:0] wr_addr;
  logic [15:0]   row, column;
`ifdef IMAGE_FRAME_WRITER_STATS_EN
  logic [AW:0]   on_count;
`endif

  image_frame_writer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .row        (row),
    .column     (column),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef IMAGE_FRAME_WRITER_STATS_EN
    .on_count   (on_count),
`endif
    .error      (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: p = flat index of next pixel, in_frame/done_cyc = stream phase.
  int m_p, m_ones, m_oncnt, m_addr;
  bit m_in_frame, m_done, m_err, m_wr, m_data;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_ones = 0; m_oncnt = 0; m_addr = 0;
    m_in_frame = 0; m_done = 0; m_err = 0; m_wr = 0; m_data = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".wr_en"}, int'(wr_en), int'(m_wr));
    chk({ctx, ".wr_addr"}, int'(wr_addr), m_addr);
    chk({ctx, ".wr_data"}, int'(wr_data), int'(m_data));
    chk({ctx, ".row"}, int'(row), m_p / W);
    chk({ctx, ".column"}, int'(column), m_p % W);
    chk({ctx, ".busy"}, int'(busy), int'(m_in_frame));
    chk({ctx, ".in_ready"}, int'(in_ready), int'(!m_done));
    chk({ctx, ".frame_done"}, int'(frame_done), int'(m_done));
    chk({ctx, ".error"}, int'(error), int'(m_err));
`ifdef IMAGE_FRAME_WRITER_STATS_EN
    chk({ctx, ".on_count"}, int'(on_count), m_oncnt);
`endif
  endtask

  // One clock with the given beat; model updated, outputs checked at +1.
  task automatic step(input string ctx, input bit v, input bit pix,
                      input bit sof, input bit eol);
    bit acc;
    in_valid = v; in_pixel = pix; in_sof = sof; in_eol = eol;
    @(posedge clk);
    acc  = v && !m_done;
    m_wr = 0;
    if (m_done) begin
      m_done  = 0;
      m_oncnt = m_ones;
    end else if (acc) begin
      if (sof) begin
        m_err = m_in_frame;
        m_in_frame = 1;
        m_p = 0;
        m_ones = 0;
      end else if (m_in_frame && (eol != (m_p % W == W - 1))) begin
        m_err = 1;
      end
      if (m_in_frame) begin
        m_wr = 1; m_addr = m_p; m_data = pix;
        m_ones += pix;
        m_p++;
        if (m_p == W * H) begin
          m_p = 0; m_in_frame = 0; m_done = 1;
        end
      end
    end
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0);
  endtask

  // Frame of n beats; pixel mode alt = alternating 1,0 else random.
  task automatic frame(input string ctx, input int n, input bit alt,
                       input int resof, input int bad_a, input int bad_b,
                       input int gap);
    int pos = 0;
    bit pix, sof, eol;
    for (int i = 0; i < n; i++) begin
      if (i == gap) idle(5);
      sof = (i == 0) || (i == resof);
      if (sof) pos = 0;
      eol = (pos % W == W - 1);
      if (i == bad_a || i == bad_b) eol = !eol;
      pix = alt ? (i % 2 == 0) : 1'($urandom);
      step(ctx, 1, pix, sof, eol);
      pos++;
    end
  endtask

  initial begin
    model_reset();
    reset = 1;
    #1;
    check_all("rst_async");
    @(negedge clk);
    reset = 0;
    step("post_rst", 0, 0, 0, 0);

    frame("alt", W * H, 1, -1, -1, -1, -1);
    // DONE cycle: the offered beat is refused, then IDLE discards it.
    step("done_beat", 1, 1, 0, 0);
    idle(2);
`ifdef IMAGE_FRAME_WRITER_STATS_EN
    chk("on_count_alt", int'(on_count), 6);
`endif

    for (int i = 0; i < 3; i++) step("nosof", 1, 1'($urandom), 0, 0);
    frame("after_nosof", W * H, 0, -1, -1, -1, -1);
    idle(2);

    frame("bad_eol", W * H, 0, -1, 2, 3, -1);
    idle(2);
    chk("err_sticky", int'(error), 1);
    frame("clear_err", W * H, 0, -1, -1, -1, -1);
    idle(2);

    frame("resof", 6 + W * H, 0, 6, -1, -1, -1);
    idle(2);

    frame("gap", W * H, 0, -1, -1, -1, 7);
    idle(2);

    for (int i = 0; i < 5; i++) step("pre_rst", 1, 1'($urandom), i == 0,
                                     i == 3);
    in_valid = 1; in_pixel = 1; in_sof = 0; in_eol = 0;
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    in_valid = 0;
    @(negedge clk);
    reset = 0;
    step("rst_after", 0, 0, 0, 0);
    frame("final", W * H, 1, -1, -1, -1, -1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
